program_loader: RTL and testbench
=================================

# program_loader

Writer side of the MIPS instruction memory. The fetch stage only reads program memory; this block fills it. It receives a byte stream from the debug UART receiver and assembles big-endian 32-bit instruction words. It writes each word to consecutive word addresses and holds the CPU (PC and pipeline) in reset until loading finishes.

## Interface

Parameters:
- ADDR_WIDTH, 8, word-address width; memory depth is 2^ADDR_WIDTH words
- END_MARKER, 32'hFFFFFFFF, word that terminates a load
- TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only when LOADER_TIMEOUT_EN is defined

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load
- rx_valid  in  1  byte strobe from the UART receiver
- rx_data  in  8  received byte
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready
- mem_we  out  1  program-memory write enable
- mem_addr  out  ADDR_WIDTH  program-memory word address
- mem_wdata  out  32  program-memory write data
- cpu_hold  out  1  forces PC and pipeline into reset while high
- done  out  1  load finished (marker written or memory full)
- overflow  out  1  sticky; memory filled before the marker arrived
- timeout  out  1  sticky; inter-byte timeout fired
- word_count  out  ADDR_WIDTH+1  number of words written in the current load

## Operation

- States: IDLE, LOAD, WRITE, DONE. Reset goes to IDLE.
- Reset values: all outputs 0; byte index 0; write pointer 0; assembly register 0.
- IDLE: rx_ready=0, cpu_hold=0.
  - start → LOAD.
  - Entering LOAD clears the write pointer, word_count, byte index, overflow and timeout.
- LOAD: rx_ready=1, cpu_hold=1.
  - Accepted byte k (0..3) is stored in bits [31-8k -: 8]; the first byte is the MSB.
  - Accepting the 4th byte → WRITE.
- WRITE: rx_ready=0, cpu_hold=1.
  - Drives mem_we=1, mem_addr=write pointer, mem_wdata=assembled word.
  - Write pointer and word_count increment; byte index returns to 0.
  - If the word equals END_MARKER, it is written (the CPU sees it as halt) → DONE.
  - Else, if the pointer was at 2^ADDR_WIDTH-1, set overflow → DONE.
  - Otherwise → LOAD.
- DONE: done=1, cpu_hold=0, rx_ready=0.
  - start → LOAD (a new load from address 0).
  - Bytes arriving in DONE are dropped.
- start is ignored in LOAD and WRITE.
- rx_valid while rx_ready=0 is not accepted. The UART receiver must hold or drop that byte; the loader never buffers it.
- mem_we is high only in WRITE; mem_addr and mem_wdata are don't-care otherwise.
- Reset mid-load goes to IDLE. Any partial word is discarded, no write is issued, and memory already written is left unchanged.

## Timing

- start sampled high in cycle N → rx_ready=1 and cpu_hold=1 in cycle N+1.
- 4th byte accepted in cycle M → mem_we=1 in cycle M+1 → rx_ready=1 again in cycle M+2, or done=1 in cycle M+2.
- word_count reflects a write in the cycle after WRITE.
- Maximum throughput: one byte per cycle, with one bubble cycle per word.
- cpu_hold falls in the same cycle done rises. The CPU leaves reset one cycle later through its own synchronous reset.

## Configuration

LOADER_TIMEOUT_EN:
- When defined:
  - A counter runs in LOAD while the byte index is nonzero; it clears on each accepted byte.
  - At TIMEOUT_CYCLES cycles with no accepted byte:
    - the partial word is discarded;
    - timeout is set;
    - the FSM goes to DONE without a write.
  - word_count keeps the complete words already written.
- When not defined:
  - no counter logic is present;
  - timeout is tied to 0;
  - LOAD waits indefinitely.

## Test plan

- Reset, then idle 5 cycles → all outputs 0, state IDLE.
- start; bytes 20 08 00 05, then FF FF FF FF → two writes:
  - addr 0 = 32'h20080005;
  - addr 1 = 32'hFFFFFFFF;
  - then done=1, word_count=2, overflow=0, cpu_hold=0.
- ADDR_WIDTH=2; 16 bytes, none forming the marker → 4 writes at addr 0..3, then overflow=1, done=1, word_count=4. Further bytes are ignored: rx_ready=0, no mem_we.
- rx_valid held high continuously during a load → exactly one rx_ready=0 bubble after every 4th byte; no byte is lost or duplicated (compare the written image to the source).
- Reset asserted after 2 bytes of the second word → no mem_we, state IDLE, word_count=0. A following start plus 8 bytes reloads from addr 0.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 1 byte, then nothing for 16 cycles → timeout=1, done=1, no write issued.

Source files
------------

// File: rtl/program_loader.sv
// Program-memory writer: assembles big-endian words from a UART byte stream and
// holds the CPU in reset while loading. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [31:0] END_MARKER     = 32'hFFFFFFFF,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  overflow,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   word_count
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [1:0]            byte_idx;
  logic [31:0]           asm_word;
  logic                  accept;
  logic                  load_start;
  logic                  ptr_last;
  logic                  is_marker;
  logic                  tmo_fire;

  assign accept     = (state == LOAD) && rx_valid;
  assign load_start = ((state == IDLE) || (state == DONE)) && start;
  assign ptr_last   = &wr_ptr;
  assign is_marker  = (asm_word == END_MARKER);

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmr;

  // Only a partially received word can time out; an empty word waits forever.
  assign tmo_fire = (state == LOAD) && !accept && (byte_idx != 2'd0) &&
                    (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr <= '0;
    end else if ((state != LOAD) || accept || (byte_idx == 2'd0) || tmo_fire) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (load_start) begin
      timeout <= 1'b0;
    end else if (tmo_fire) begin
      timeout <= 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        if (tmo_fire) begin
          state_nxt = DONE;
        end else if (accept && (byte_idx == 2'd3)) begin
          state_nxt = WRITE;
        end
      end
      WRITE:   state_nxt = (is_marker || ptr_last) ? DONE : LOAD;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    cpu_hold  = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    mem_addr  = wr_ptr;
    mem_wdata = asm_word;
    case (state)
      LOAD: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      WRITE: begin
        cpu_hold = 1'b1;
        mem_we   = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      word_count <= '0;
      byte_idx   <= 2'd0;
      asm_word   <= 32'd0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            wr_ptr     <= '0;
            word_count <= '0;
            byte_idx   <= 2'd0;
            overflow   <= 1'b0;
          end
        end
        LOAD: begin
          if (tmo_fire) begin
            byte_idx <= 2'd0;
          end else if (accept) begin
            case (byte_idx)
              2'd0:    asm_word[31:24] <= rx_data;
              2'd1:    asm_word[23:16] <= rx_data;
              2'd2:    asm_word[15:8]  <= rx_data;
              default: asm_word[7:0]   <= rx_data;
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          wr_ptr     <= wr_ptr + 1'b1;
          word_count <= word_count + 1'b1;
          byte_idx   <= 2'd0;
          // A marker landing in the last slot is a clean finish, not an overflow.
          if (!is_marker && ptr_last) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (ADDR_WIDTH=2, TIMEOUT_CYCLES=16).
module tb_program_loader;

  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, mem_we, cpu_hold, done, overflow, timeout;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  program_loader #(.ADDR_WIDTH(AW), .END_MARKER(32'hFFFFFFFF), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow), .timeout(timeout),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [4];
  int          nwrites = 0;

  always @(posedge clock) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      nwrites++;
    end
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        hold;
    logic        dn;
    logic        ovf;
    logic [2:0]  wc;
  } vec_t;

  function automatic vec_t v(logic st, logic vld, logic [7:0] d, logic rdy, logic we,
                             logic [1:0] addr, logic [31:0] wd, logic hold, logic dn,
                             logic ovf, logic [2:0] wc);
    vec_t r;
    r.st = st; r.vld = vld; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr; r.wd = wd;
    r.hold = hold; r.dn = dn; r.ovf = ovf; r.wc = wc;
    return r;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (k >= 20) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t        tbl [13];
  logic [7:0]  src [16];
  logic [31:0] w;
  int          idx, gap;

  initial begin
    tbl[0]  = v(1, 0, 8'h00, 0, 0, 0, 0,            0, 0, 0, 0);
    tbl[1]  = v(0, 1, 8'h20, 1, 0, 0, 0,            1, 0, 0, 0);
    tbl[2]  = v(0, 1, 8'h08, 1, 0, 0, 0,            1, 0, 0, 0);
    tbl[3]  = v(0, 1, 8'h00, 1, 0, 0, 0,            1, 0, 0, 0);
    tbl[4]  = v(0, 1, 8'h05, 1, 0, 0, 0,            1, 0, 0, 0);
    tbl[5]  = v(0, 0, 8'h00, 0, 1, 0, 32'h20080005, 1, 0, 0, 0);
    tbl[6]  = v(0, 1, 8'hFF, 1, 0, 0, 0,            1, 0, 0, 1);
    tbl[7]  = v(0, 1, 8'hFF, 1, 0, 0, 0,            1, 0, 0, 1);
    tbl[8]  = v(0, 1, 8'hFF, 1, 0, 0, 0,            1, 0, 0, 1);
    tbl[9]  = v(0, 1, 8'hFF, 1, 0, 0, 0,            1, 0, 0, 1);
    tbl[10] = v(0, 0, 8'h00, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0, 1);
    tbl[11] = v(0, 1, 8'h12, 0, 0, 0, 0,            0, 1, 0, 2);
    tbl[12] = v(0, 0, 8'h00, 0, 0, 0, 0,            0, 1, 0, 2);
    for (int i = 0; i < 16; i++) src[i] = 8'(8'h10 + i);

    // Reset then idle: every output must be zero.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("idle_outputs",
        {20'd0, rx_ready, mem_we, mem_addr, cpu_hold, done, overflow, timeout, word_count},
        32'd0);
    chk("idle_wdata", mem_wdata, 32'd0);

    // Two-word load ending in the marker, cycle by cycle.
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d_rx_ready", i), 32'(rx_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_cpu_hold", i), 32'(cpu_hold), 32'(tbl[i].hold));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_word_count", i), 32'(word_count), 32'(tbl[i].wc));
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
        chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].wd);
      end
      start    = tbl[i].st;
      rx_valid = tbl[i].vld;
      rx_data  = tbl[i].d;
      @(negedge clock);
    end
    start = 1'b0;
    rx_valid = 1'b0;
    chk("marker_nwrites", 32'(nwrites), 32'd2);
    chk("marker_mem0", mem[0], 32'h20080005);
    chk("marker_mem1", mem[1], 32'hFFFFFFFF);

    // Continuous rx_valid until memory fills: one bubble per word, then overflow.
    nwrites = 0;
    for (int i = 0; i < 4; i++) mem[i] = 32'd0;
    pulse_start();
    idx = 0;
    gap = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      rx_valid = 1'b1;
      rx_data  = (idx < 16) ? src[idx] : 8'h00;
      if (rx_ready) begin
        if (idx > 0) chk($sformatf("bubble_before_byte%0d", idx), 32'(gap),
                         (idx % 4 == 0) ? 32'd1 : 32'd0);
        gap = 0;
        idx++;
      end else if (idx > 0) begin
        gap++;
      end
      @(negedge clock);
    end
    chk("ovf_bytes_taken", 32'(idx), 32'd16);
    chk("ovf_nwrites", 32'(nwrites), 32'd4);
    for (int i = 0; i < 4; i++) begin
      w = {src[4*i], src[4*i+1], src[4*i+2], src[4*i+3]};
      chk($sformatf("ovf_mem%0d", i), mem[i], w);
    end
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_word_count", 32'(word_count), 32'd4);
    chk("ovf_cpu_hold", 32'(cpu_hold), 32'd0);
    for (int c = 0; c < 6; c++) begin
      rx_data = 8'hA5;
      chk("ovf_after_rx_ready", 32'(rx_ready), 32'd0);
      chk("ovf_after_mem_we", 32'(mem_we), 32'd0);
      @(negedge clock);
    end
    rx_valid = 1'b0;
    chk("ovf_after_nwrites", 32'(nwrites), 32'd4);

    // Reset in the middle of the second word, then reload.
    nwrites = 0;
    pulse_start();
    chk("rst_overflow_cleared", 32'(overflow), 32'd0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_state_idle", {29'd0, rx_ready, cpu_hold, done}, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_nwrites", 32'(nwrites), 32'd1);
    chk("rst_mem0_kept", mem[0], 32'hAABBCCDD);
    pulse_start();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    @(negedge clock);
    chk("reload_nwrites", 32'(nwrites), 32'd3);
    chk("reload_mem0", mem[0], 32'h01020304);
    chk("reload_mem1", mem[1], 32'h05060708);
    chk("reload_word_count", 32'(word_count), 32'd2);
    chk("reload_rx_ready", 32'(rx_ready), 32'd1);

`ifdef LOADER_TIMEOUT_EN
    // One byte then silence: fires after exactly 16 idle cycles, no write.
    send_byte(8'h55);
    repeat (15) @(negedge clock);
    chk("tmo_not_yet_done", 32'(done), 32'd0);
    @(negedge clock);
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_timeout", 32'(timeout), 32'd1);
    chk("tmo_nwrites", 32'(nwrites), 32'd3);
    chk("tmo_word_count", 32'(word_count), 32'd2);
`else
    repeat (20) @(negedge clock);
    chk("no_tmo_timeout", 32'(timeout), 32'd0);
    chk("no_tmo_still_load", 32'(rx_ready), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
